board_input_capture: RTL and testbench



---
 rtl/board_input_capture.sv | 120 ++++++++++++
 tb/tb_board_input_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_capture.sv
// board_input_capture
//   Captures the board slide switches and push buttons for the CPU. Each raw
//   line is synchronised, debounced, and buttons are edge-detected into sticky
//   event bits. A single-cycle read port with a registered response returns
//   switch levels, button levels or button events. Reading the events clears them.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   sw        raw asynchronous switch levels
//   btn       raw asynchronous button levels, 1 = pressed
//   rd_en     read request
//   rd_sel    0 switches, 1 button levels, 2 button events (read-clear), 3 reserved
//   rd_data   registered read data, zero-extended
//   rd_valid  one-cycle pulse, rd_data valid
//   btn_irq   high while any button event bit is set
module board_input_capture #(
    parameter int unsigned NUM_SW          = 16,
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               rd_en,
    input  logic [1:0]         rd_sel,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic               btn_irq
);

    // Switches and buttons share one synchroniser/debounce vector: buttons on top.
    localparam int unsigned NUM_IN = NUM_SW + NUM_BTN;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_IN-1:0]  synced;
    logic [NUM_IN-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q [NUM_IN];
    logic [CNT_W-1:0]   cnt_d [NUM_IN];
    logic [NUM_BTN-1:0] event_q, event_d;
    logic [NUM_BTN-1:0] btn_stable, btn_stable_d, btn_rise;
    logic [NUM_BTN-1:0] rd_clear;
    logic [NUM_SW-1:0]  sw_stable;
    logic [31:0]        rd_word;

    // Plain flop chain, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {btn, sw};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // A level is accepted after DEBOUNCE_CYCLES consecutive mismatches. The
    // counter clears on the accepting cycle, so it never passes CNT_MAX.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sw_stable    = stable_q[NUM_SW-1:0];
    assign btn_stable   = stable_q[NUM_IN-1:NUM_SW];
    assign btn_stable_d = stable_d[NUM_IN-1:NUM_SW];
    assign btn_rise     = btn_stable_d & ~btn_stable;

    always_comb begin
        rd_word  = '0;
        rd_clear = '0;
        case (rd_sel)
            2'd0: rd_word[NUM_SW-1:0] = sw_stable;
            2'd1: rd_word[NUM_BTN-1:0] = btn_stable;
            2'd2: begin
                rd_word[NUM_BTN-1:0] = event_q;
                rd_clear             = {NUM_BTN{rd_en}};
            end
            default: rd_word = '0;
        endcase
    end

    // A rise on the same edge as a clearing read wins, so no press is lost.
    assign event_d = (event_q & ~rd_clear) | btn_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
            event_q  <= '0;
            btn_irq  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
            event_q  <= event_d;
            btn_irq  <= |event_q;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_board_input_capture.sv
// Testbench for board_input_capture with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// The reference model treats a line as accepted once its last DEBOUNCE_CYCLES
// synchronised samples all differ from the accepted level.
module tb_board_input_capture;

    localparam int NSW  = 16;
    localparam int NBTN = 5;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int NIN  = NSW + NBTN;
    localparam int HL   = SYNC + DEB - 1;

    logic            clk;
    logic            rst_n;
    logic [NSW-1:0]  sw;
    logic [NBTN-1:0] btn;
    logic            rd_en;
    logic [1:0]      rd_sel;
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic            btn_irq;

    board_input_capture #(
        .NUM_SW          (NSW),
        .NUM_BTN         (NBTN),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn      (btn),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .btn_irq  (btn_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [NIN-1:0]  hist [HL];   // raw samples of the last HL edges, oldest first
    logic [NIN-1:0]  m_stable;
    logic [NBTN-1:0] m_event;
    logic            m_irq;
    logic            m_valid;
    logic [31:0]     m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist[k] = '0;
        m_stable = '0;
        m_event  = '0;
        m_irq    = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [NIN-1:0]  new_st;
        logic [NBTN-1:0] rise;
        logic [NBTN-1:0] clr;
        logic            all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        new_st = m_stable;
        for (int i = 0; i < NIN; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) new_st[i] = ~m_stable[i];
        end
        rise = new_st[NIN-1:NSW] & ~m_stable[NIN-1:NSW];
        clr  = '0;
        if (rd_en) begin
            m_valid = 1'b1;
            case (rd_sel)
                2'd0: m_data = {16'b0, m_stable[NSW-1:0]};
                2'd1: m_data = {27'b0, m_stable[NIN-1:NSW]};
                2'd2: begin
                    m_data = {27'b0, m_event};
                    clr    = '1;
                end
                default: m_data = 32'h0;
            endcase
        end else begin
            m_valid = 1'b0;
        end
        m_irq    = |m_event;
        m_event  = (m_event & ~clr) | rise;
        m_stable = new_st;
        for (int k = 0; k < HL - 1; k++) hist[k] = hist[k+1];
        hist[HL-1] = {btn, sw};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_data", rd_data, m_data);
        check("btn_irq", 32'(btn_irq), 32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read(input logic [1:0] sel);
        rd_en  = 1'b1;
        rd_sel = sel;
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", 32'(rd_valid), 32'h0);
        check("async_rst_data", rd_data, 32'h0);
        check("async_rst_irq", 32'(btn_irq), 32'h0);
    endtask

    initial begin
        // Reset with inputs held high
        rst_n  = 1'b0;
        sw     = 16'hA5A5;
        btn    = 5'h1F;
        rd_en  = 1'b0;
        rd_sel = 2'd0;
        model_reset();
        #3;
        check("reset_valid", 32'(rd_valid), 32'h0);
        check("reset_data", rd_data, 32'h0);
        check("reset_irq", 32'(btn_irq), 32'h0);
        ticks(3);
        rst_n = 1'b1;
        ticks(6);
        read(2'd0);
        check("post_reset_sw", rd_data, 32'h0000A5A5);
        read(2'd2);
        check("post_reset_events", rd_data, 32'h1F);

        // Debounce latency on sw[3]
        sw[3] = 1'b1;
        ticks(5);
        read(2'd0);
        check("latency_bit3_early", 32'(rd_data[3]), 32'h0);
        read(2'd0);
        check("latency_bit3_taken", 32'(rd_data[3]), 32'h1);

        // Release all buttons, no events on release
        btn = '0;
        ticks(8);
        read(2'd2);
        check("release_no_event", rd_data, 32'h0);

        // Glitch rejection on btn[2]
        btn[2] = 1'b1;
        ticks(3);
        btn[2] = 1'b0;
        ticks(8);
        check("glitch_irq", 32'(btn_irq), 32'h0);
        read(2'd1);
        check("glitch_level", rd_data, 32'h0);
        read(2'd2);
        check("glitch_event", rd_data, 32'h0);

        // Event and clear on btn[1]
        btn[1] = 1'b1;
        ticks(10);
        check("press_irq", 32'(btn_irq), 32'h1);
        btn[1] = 1'b0;
        read(2'd2);
        check("press_event", rd_data, 32'h2);
        check("press_valid", 32'(rd_valid), 32'h1);
        read(2'd2);
        check("press_cleared", rd_data, 32'h0);
        check("press_irq_drop", 32'(btn_irq), 32'h0);
        ticks(8);

        // Stable rise of btn[0] on the same edge as a clearing read
        btn[0] = 1'b1;
        ticks(5);
        read(2'd2);
        check("collide_read", rd_data, 32'h0);
        read(2'd2);
        check("collide_kept", rd_data, 32'h1);
        ticks(2);

        // Back-to-back reads including reserved, then reset mid-sequence
        rd_en  = 1'b1;
        rd_sel = 2'd0;
        tick();
        check("b2b_sw", rd_data, 32'h0000A5AD);
        check("b2b_valid0", 32'(rd_valid), 32'h1);
        rd_sel = 2'd3;
        tick();
        check("b2b_reserved", rd_data, 32'h0);
        check("b2b_valid1", 32'(rd_valid), 32'h1);
        rd_sel = 2'd1;
        tick();
        check("b2b_btn", rd_data, 32'h1);
        check("b2b_valid2", 32'(rd_valid), 32'h1);
        rd_sel = 2'd0;
        tick();
        reset_now();
        rd_en = 1'b0;
        ticks(2);
        rst_n = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) begin
                int idx;
                idx = int'($urandom_range(NSW - 1));
                sw[idx] = ~sw[idx];
            end
            for (int b = 0; b < NBTN; b++) begin
                if ($urandom_range(5) == 0) btn[b] = ~btn[b];
            end
            rd_en  = 1'($urandom_range(1));
            rd_sel = 2'($urandom_range(3));
            if (i == 300) begin
                reset_now();
                ticks(2);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
